// File: rtl/motor_ramp_ctrl_if.sv
// rtl/motor_ramp_ctrl_if.sv - command handshake bundle for motor_ramp_ctrl
//   cmd_valid : command offered by the master
//   cmd_ready : controller can accept a command this cycle
//   cmd_dir   : requested direction (00 backward, 01 left, 10 right, 11 forward)
//   cmd_speed : requested duty 0..1023
interface motor_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [9:0] cmd_speed;

    modport master (output cmd_valid, output cmd_dir, output cmd_speed, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - motor speed/direction ramp controller with reversal dwell
//   c100MHz   : clock
//   rst_n     : asynchronous active-low reset
//   cmd       : command handshake (motor_ramp_ctrl_if.slave)
//   dir       : direction driven to the motor driver
//   speed     : duty driven to the motor driver
//   at_target : high while the controller is idle at its target
//   wdog_trip : command watchdog tripped (constant 0 unless MOTOR_RAMP_WDOG_EN is defined)
// Optional build macro: MOTOR_RAMP_WDOG_EN enables the command watchdog.
module motor_ramp_ctrl #(
    parameter int RAMP_DIV   = 100_000,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 50,
    parameter int WDOG_TICKS = 500
) (
    input  logic                 c100MHz,
    input  logic                 rst_n,
    motor_ramp_ctrl_if.slave     cmd,
    output logic [1:0]           dir,
    output logic [9:0]           speed,
    output logic                 at_target,
    output logic                 wdog_trip
);
    localparam int          PS_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int          DW_W   = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [10:0] STEP11 = 11'(RAMP_STEP);

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_STOP, ST_DWELL} state_t;

    state_t           state, state_n;
    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic             rdy_q;
    logic             ready;
    logic             accept;
    logic [1:0]       tgt_dir, tgt_dir_n, dir_n;
    logic [9:0]       tgt_speed, tgt_speed_n, speed_n;
    logic [DW_W-1:0]  dwell_cnt, dwell_n;

    // One step toward tgt, computed at 11 bits so neither end can wrap.
    function automatic logic [9:0] ramp_to(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] up;
        logic [10:0] dn;
        logic [10:0] res;
        up = {1'b0, cur} + STEP11;
        if (up > 11'd1023) up = 11'd1023;
        dn = ({1'b0, cur} > STEP11) ? ({1'b0, cur} - STEP11) : 11'd0;
        if (cur < tgt)      res = (up > {1'b0, tgt}) ? {1'b0, tgt} : up;
        else if (cur > tgt) res = (dn < {1'b0, tgt}) ? {1'b0, tgt} : dn;
        else                res = {1'b0, cur};
        return res[9:0];
    endfunction

    assign tick      = (ps_cnt == PS_W'(RAMP_DIV - 1));
    // rdy_q keeps ready low while reset is held and rises on the first clock after release.
    assign ready     = rdy_q && (state != ST_DWELL);
    assign cmd.cmd_ready = ready;
    assign accept    = cmd.cmd_valid && ready;
    assign at_target = (state == ST_IDLE);

`ifdef MOTOR_RAMP_WDOG_EN
    localparam int WD_W = $clog2(WDOG_TICKS + 1);
    logic [WD_W-1:0] wdog_cnt, wdog_cnt_n;
    logic            wdog_q, wdog_n;
    assign wdog_trip = wdog_q;
`else
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        speed_n     = speed;
        dir_n       = dir;
        tgt_dir_n   = tgt_dir;
        tgt_speed_n = tgt_speed;
        dwell_n     = dwell_cnt;
`ifdef MOTOR_RAMP_WDOG_EN
        wdog_cnt_n  = wdog_cnt;
        wdog_n      = wdog_q;
`endif
        case (state)
            ST_IDLE: ;
            ST_RAMP: begin
                if (speed == tgt_speed) state_n = ST_IDLE;
                else if (tick)          speed_n = ramp_to(speed, tgt_speed);
            end
            ST_STOP: begin
                if (speed == 10'd0) begin
                    state_n = ST_DWELL;
                    dwell_n = '0;
                end else if (tick) begin
                    speed_n = ramp_to(speed, 10'd0);
                end
            end
            ST_DWELL: begin
                speed_n = 10'd0;
                if (tick) begin
                    if (dwell_cnt == DW_W'(DEAD_TICKS - 1)) begin
                        // Only place dir ever changes, and speed is 0 here.
                        dir_n   = tgt_dir;
                        state_n = (tgt_speed == 10'd0) ? ST_IDLE : ST_RAMP;
                        dwell_n = '0;
                    end else begin
                        dwell_n = dwell_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Acceptance wins over the tick; a coincident tick steps toward the new target.
        if (accept) begin
            tgt_dir_n   = cmd.cmd_dir;
            tgt_speed_n = cmd.cmd_speed;
            if (cmd.cmd_dir == dir) begin
                if (cmd.cmd_speed == speed) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RAMP;
                    if (tick) speed_n = ramp_to(speed, cmd.cmd_speed);
                end
            end else if (speed != 10'd0) begin
                state_n = ST_STOP;
                if (tick) speed_n = ramp_to(speed, 10'd0);
            end else begin
                state_n = ST_DWELL;
                speed_n = 10'd0;
                dwell_n = '0;
            end
        end

`ifdef MOTOR_RAMP_WDOG_EN
        if (accept) begin
            wdog_cnt_n = '0;
            wdog_n     = 1'b0;
        end else if (tick && !wdog_q) begin
            if (wdog_cnt == WD_W'(WDOG_TICKS - 1)) begin
                wdog_n      = 1'b1;
                tgt_speed_n = 10'd0;
                // A reversal in progress already heads to 0; leave STOP/DWELL to finish.
                if (state == ST_IDLE || state == ST_RAMP) state_n = ST_RAMP;
            end else begin
                wdog_cnt_n = wdog_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge c100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ps_cnt    <= '0;
            rdy_q     <= 1'b0;
            dir       <= 2'b11;
            speed     <= 10'd0;
            tgt_dir   <= 2'b11;
            tgt_speed <= 10'd0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_n;
            ps_cnt    <= tick ? '0 : ps_cnt + 1'b1;
            rdy_q     <= 1'b1;
            dir       <= dir_n;
            speed     <= speed_n;
            tgt_dir   <= tgt_dir_n;
            tgt_speed <= tgt_speed_n;
            dwell_cnt <= dwell_n;
        end
    end

`ifdef MOTOR_RAMP_WDOG_EN
    always_ff @(posedge c100MHz or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            wdog_cnt <= wdog_cnt_n;
            wdog_q   <= wdog_n;
        end
    end
`endif
endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): RAMP_DIV, 100_000, clocks per ramp tick (1 kHz at 100 MHz).
REQ-002 SHALL have parameter RAMP_STEP, 8, speed units added or removed per tick.
REQ-003 SHALL have parameter DEAD_TICKS, 50, zero-speed dwell ticks before any direction change.
REQ-004 SHALL have parameter WDOG_TICKS, 500, ticks without an accepted command before a watchdog trip.
REQ-005 SHALL have port (name, direction, width, meaning): c100MHz, in, 1, the single clock.
REQ-006 SHALL have port rst_n, in, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid, in, 1, command offered.
REQ-008 SHALL have port cmd_ready, out, 1, command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_dir, in, 2, requested direction (00 backward, 01 left, 10 right, 11 forward).
REQ-010 SHALL have port cmd_speed, in, 10, requested duty (0..1023).
REQ-011 SHALL have port dir, out, 2, direction driven to the motor driver.
REQ-012 SHALL have port speed, out, 10, duty driven to the motor driver.
REQ-013 SHALL have port at_target, out, 1, high when state is IDLE.
REQ-014 SHALL have port wdog_trip, out, 1, watchdog trip flag.

Function
REQ-015 SHALL run a free-running prescaler that emits a 1-cycle tick every RAMP_DIV clocks.
REQ-016 SHALL implement the states IDLE, RAMP, STOP and DWELL.
REQ-017 SHALL register an accepted command as tgt_dir/tgt_speed; the last accepted command wins.
REQ-018 SHALL drive cmd_ready high in IDLE, RAMP and STOP, and low in DWELL.
REQ-019 SHALL leave dir unchanged when an accepted command has cmd_dir==dir; the state goes to RAMP the next cycle, or stays IDLE if cmd_speed==speed.
REQ-020 SHALL, when an accepted command has cmd_dir!=dir and speed!=0, enter STOP the next cycle.
REQ-021 SHALL, when an accepted command has cmd_dir!=dir and speed==0, enter DWELL the next cycle.
REQ-022 SHALL, in RAMP on each tick, set speed to min(speed+RAMP_STEP, tgt_speed) when below target, or to max(speed-RAMP_STEP, tgt_speed) when above.
REQ-023 SHALL compute ramp arithmetic at 11 bits and saturate it to 0..1023; speed never wraps.
REQ-024 SHALL move RAMP to IDLE in the cycle after speed equals tgt_speed.
REQ-025 SHALL, in STOP, decrement speed toward 0 per tick using the same saturation, and enter DWELL once speed==0.
REQ-026 SHALL, if a command accepted in STOP has cmd_dir==dir, abort the reversal and enter RAMP with the new target.
REQ-027 SHALL hold speed at 0 in DWELL for DEAD_TICKS ticks, then load dir<=tgt_dir and enter RAMP (or IDLE if tgt_speed==0).
REQ-028 SHALL change dir only on the DWELL exit cycle, so dir never changes while speed!=0.
REQ-029 SHALL give priority to acceptance over a tick in the same cycle; the tick then uses the new target.

Reset
REQ-030 SHALL, while rst_n is low, force state=IDLE, dir=2'b11, speed=0, tgt_dir=2'b11, tgt_speed=0, prescaler=0, dwell and watchdog counters=0, and wdog_trip=0.
REQ-031 SHALL, when reset is asserted mid-ramp or in DWELL, drop speed to 0 immediately and asynchronously.
REQ-032 SHALL drive cmd_ready low during reset and high from the first clock after release.

Configuration
REQ-033 SHALL, with macro MOTOR_RAMP_WDOG_EN defined, count ticks since the last accepted command, and at WDOG_TICKS set tgt_speed=0, assert wdog_trip and enter RAMP (toward 0).
REQ-034 SHALL, with MOTOR_RAMP_WDOG_EN defined, clear wdog_trip and the watchdog counter on the next accepted command.
REQ-035 SHALL, without MOTOR_RAMP_WDOG_EN, build no watchdog logic, tie wdog_trip to 0, and keep the port present.

Verification (RAMP_DIV=4, RAMP_STEP=100, DEAD_TICKS=3, WDOG_TICKS=20)
REQ-036 SHALL verify: from reset, accept {11, 350} -> speed 100, 200, 300, 350 on successive ticks, then at_target=1.
REQ-037 SHALL verify: at speed 350 forward, accept {00, 200} -> speed 250, 150, 50, 0 with dir=11, then 3 ticks at 0 and cmd_ready=0, then dir=00 and speed ramps 100, 200.
REQ-038 SHALL verify: during STOP at speed 150, accept {11, 500} -> no DWELL, dir stays 11, speed ramps 250 ... 500.
REQ-039 SHALL verify: command acceptance and a tick in the same cycle -> the step is taken toward the new target.
REQ-040 SHALL verify: rst_n pulsed low during DWELL -> speed=0, dir=11, state IDLE, cmd_ready high one clock after release.
REQ-041 SHALL verify: with MOTOR_RAMP_WDOG_EN, hold at 300 for 20 ticks without a command -> wdog_trip=1 and speed 200, 100, 0; the next command clears wdog_trip.
